// File: rtl/ksa_multiword_adder_pkg.sv
// ============================================================================
//  Module      : ksa_multiword_adder_pkg
//  Description : Shared state encoding, op codes and sizing helper for the
//                multi-word Kogge-Stone adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ksa_multiword_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Chunk counter width; a single-bit counter is kept even for degenerate sizes.
    function automatic int ctr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ksa_multiword_adder_if.sv
// ============================================================================
//  Module      : ksa_multiword_adder_if
//  Description : Operand request / result response bundle of the multi-word
//                adder, with master (producer/consumer) and slave (adder) views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ksa_multiword_adder_if #(
    parameter int N     = 16,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         op;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    modport master (
        output in_valid, a, b, ci, op, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, op, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );

endinterface

`default_nettype wire

// File: rtl/ksa_nbit.sv
// ============================================================================
//  Module      : ksa_nbit
//  Description : N-bit combinational Kogge-Stone adder with carry-in/out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ksa_nbit #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    localparam int LEVELS = $clog2(N);

    logic [N-1:0] w_prop;
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;

    assign w_prop = a ^ b;

    // Carry-in is folded into bit 0's generate, so w_g[i] ends up as the
    // carry out of bit i. Descending i lets each level update in place.
    always_comb begin
        w_p = w_prop;
        w_g = (a & b) | {{(N-1){1'b0}}, w_prop[0] & ci};
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = N - 1; i >= (1 << l); i--) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
        end
    end

    assign sum = w_prop ^ {w_g[N-2:0], ci};
    assign co  = w_g[N-1];

endmodule

`default_nettype wire

// File: rtl/ksa_multiword_adder.sv
// ============================================================================
//  Module      : ksa_multiword_adder
//  Description : Sequential W-bit adder/subtractor, one N-bit Kogge-Stone
//                chunk per clock, LSB chunk first, carry chained in a register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ksa_multiword_adder
    import ksa_multiword_adder_pkg::*;
#(
    parameter int N     = 16,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ksa_multiword_adder_if.slave  bus,
    output logic                  busy
);

    localparam int W  = N * WORDS;
    localparam int KW = ctr_width(WORDS);
    localparam logic [KW-1:0] c_LAST_K = KW'(WORDS - 1);

    state_e        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic [KW-1:0] r_k;
    logic          r_carry;
    logic          r_co;
    logic          r_ovf;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic [N-1:0]  w_core_sum;
    logic          w_core_co;
    logic          w_last;
    logic          w_msb_cin;

    ksa_nbit #(
        .N (N)
    ) u_core (
        .a   (r_a[r_k*N +: N]),
        .b   (r_b[r_k*N +: N]),
        .ci  (r_carry),
        .sum (w_core_sum),
        .co  (w_core_co)
    );

    assign w_last    = (r_k == c_LAST_K);
    // Carry into the MSB recovered from its sum bit; only meaningful on the last chunk.
    assign w_msb_cin = r_a[W-1] ^ r_b[W-1] ^ w_core_sum[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_co        <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        r_carry    <= (bus.op == OP_SUB) ? 1'b1 : bus.ci;
                        r_k        <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum[r_k*N +: N] <= w_core_sum;
                    r_carry           <= w_core_co;
                    if (w_last) begin
                        r_co        <= w_core_co;
                        r_ovf       <= w_msb_cin ^ w_core_co;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.co        = r_co;
    assign bus.ovf       = r_ovf;
    assign busy          = r_busy;

endmodule

`default_nettype wire
